// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - ALUOp codes and execute-stage FSM states for alu_pipe
package alu_pipe_pkg;

    localparam logic [4:0] ALUOP_NOP   = 5'b00000;
    localparam logic [4:0] ALUOP_LUI   = 5'b00001;
    localparam logic [4:0] ALUOP_AUIPC = 5'b00010;
    localparam logic [4:0] ALUOP_ADD   = 5'b00011;
    localparam logic [4:0] ALUOP_SUB   = 5'b00100;
    localparam logic [4:0] ALUOP_AND   = 5'b00101;
    localparam logic [4:0] ALUOP_OR    = 5'b00110;
    localparam logic [4:0] ALUOP_XOR   = 5'b00111;
    localparam logic [4:0] ALUOP_SLL   = 5'b01000;
    localparam logic [4:0] ALUOP_SRL   = 5'b01001;
    localparam logic [4:0] ALUOP_SRA   = 5'b01010;
    localparam logic [4:0] ALUOP_SLT   = 5'b01011;
    localparam logic [4:0] ALUOP_SLTU  = 5'b01100;
    localparam logic [4:0] ALUOP_MUL   = 5'b01101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one partial product per cycle
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] acc_step;

    // product_o already includes the step of the current cycle, so the final
    // partial product can be captured by the consumer on the same edge.
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o    = busy_q && (count_q == CW'(WIDTH - 1));
    assign product_o = acc_step;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        busy_d   = busy_q;
        if (flush_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            count_d  = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered execute-stage ALU with valid/ready handshakes and iterative multiply
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int OPW    = 5,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OPW-1:0]   ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             Zero,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             zero_q, zero_d;
    logic             ill_q, ill_d;
    logic             ov_q, ov_d;

    logic             accept;
    logic             op_is_mul;
    logic             op_illegal;
    logic [WIDTH-1:0] op_res;
    logic [SHW-1:0]   shamt;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    assign shamt    = B[SHW-1:0];
    assign in_ready = rstn && (state_q == ST_IDLE) && (!ov_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    assign C         = c_q;
    assign Zero      = zero_q;
    assign illegal   = ill_q;
    assign out_valid = ov_q;

    always_comb begin
        op_res     = '0;
        op_illegal = 1'b0;
        op_is_mul  = 1'b0;
        case (ALUOp)
            OPW'(ALUOP_NOP):   op_res = c_q;
            OPW'(ALUOP_LUI):   op_res = B;
            OPW'(ALUOP_AUIPC),
            OPW'(ALUOP_ADD):   op_res = A + B;
            OPW'(ALUOP_SUB):   op_res = A - B;
            OPW'(ALUOP_AND):   op_res = A & B;
            OPW'(ALUOP_OR):    op_res = A | B;
            OPW'(ALUOP_XOR):   op_res = A ^ B;
            OPW'(ALUOP_SLL):   op_res = A << shamt;
            OPW'(ALUOP_SRL):   op_res = A >> shamt;
            OPW'(ALUOP_SRA):   op_res = $unsigned($signed(A) >>> shamt);
            OPW'(ALUOP_SLT):   op_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            OPW'(ALUOP_SLTU):  op_res = {{(WIDTH-1){1'b0}}, A < B};
            OPW'(ALUOP_MUL): begin
                if (MUL_EN) begin
                    op_is_mul = 1'b1;
                end else begin
                    op_illegal = 1'b1;
                end
            end
            default:           op_illegal = 1'b1;
        endcase
    end

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk       (clk),
                .rstn      (rstn),
                .flush_i   (flush),
                .start_i   (accept && op_is_mul),
                .a_i       (A),
                .b_i       (B),
                .done_o    (mul_done),
                .product_o (mul_prod)
            );
        end else begin : g_no_mul
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

    // DONE holds the multiply result until the consumer takes it; no new
    // operation is accepted until the FSM is back in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && op_is_mul) begin
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (mul_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Flush drops the pending result but leaves C as it was.
    always_comb begin
        c_d   = c_q;
        ill_d = ill_q;
        ov_d  = ov_q;
        if (flush) begin
            ov_d = 1'b0;
        end else if (accept && !op_is_mul) begin
            c_d   = op_res;
            ill_d = op_illegal;
            ov_d  = 1'b1;
        end else if ((state_q == ST_MUL) && mul_done) begin
            c_d   = mul_prod;
            ill_d = 1'b0;
            ov_d  = 1'b1;
        end else if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end
        zero_d = (c_d == '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            zero_q  <= 1'b1;
            ill_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            zero_q  <= zero_d;
            ill_q   <= ill_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized self-checking bench for alu_pipe against a behavioural model
module tb_alu_pipe;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rstn, flush, in_valid, in_ready, out_valid, out_ready, Zero, illegal;
    logic [W-1:0]  A, B, C;
    logic [4:0]    ALUOp;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int acc_cnt  = 0;
    int hs_cnt   = 0;

    typedef struct {
        logic [31:0] c;
        logic        ill;
        logic [31:0] prev;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_c = '0;

    alu_pipe #(.WIDTH(W), .OPW(5), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALUOp     (ALUOp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .Zero      (Zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour straight from the op definitions, in plain arithmetic.
    function automatic exp_t ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] prev);
        exp_t        e;
        int unsigned sh;
        logic [63:0] p;
        e.c = '0; e.ill = 1'b0; e.prev = prev;
        sh = b % 32;
        case (op)
            0:       e.c = prev;
            1:       e.c = b;
            2, 3:    e.c = a + b;
            4:       e.c = a - b;
            5:       e.c = a & b;
            6:       e.c = a | b;
            7:       e.c = a ^ b;
            8:       e.c = a << sh;
            9:       e.c = a >> sh;
            10:      e.c = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            11:      e.c = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            12:      e.c = (a < b) ? 32'd1 : 32'd0;
            13: begin
                p = 64'(a) * 64'(b);
                e.c = p[31:0];
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: looks at what the coming edge will do and checks outputs against the model queue.
    always begin
        @(negedge clk);
        #2;
        if (!rstn) begin
            sb.delete();
            model_c = '0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    check("C", C, sb[0].c);
                    check("Zero", Zero, sb[0].c == 32'h0);
                    check("illegal", illegal, sb[0].ill);
                end
            end
            if (sb.size() > 0 && (out_valid ? (out_ready || flush) : flush)) begin
                if (out_valid && out_ready) hs_cnt++;
                if (!out_valid) model_c = sb[0].prev;
                void'(sb.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e = ref_op(ALUOp, A, B, model_c);
                sb.push_back(e);
                model_c = e.c;
                acc_cnt++;
            end
        end
    end

    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int tries = 0;
        @(negedge clk);
        in_valid = 1'b1; ALUOp = op; A = a; B = b;
        #1;
        while (!in_ready && tries < 100) begin
            @(negedge clk);
            #1;
            tries++;
        end
        check("send_accept", in_ready, 1);
        acc_cyc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output int rdy_seen);
        int n = 0;
        rdy_seen = 0;
        #1;
        while (!out_valid && n < 200) begin
            if (in_ready) rdy_seen++;
            @(negedge clk);
            #1;
            n++;
        end
        check("wait_out", out_valid, 1);
        lat = cyc - acc_cyc + 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat, rdy, seen, a0, h0, r;
        logic [31:0] exp_v;

        rstn = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; ALUOp = '0;
        #2 rstn = 1'b0;
        #1;
        check("rst_C", C, 0);
        check("rst_Zero", Zero, 1);
        check("rst_illegal", illegal, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1 check("post_rst_in_ready", in_ready, 1);

        send(5'd3, 32'd7, 32'hFFFF_FFF9);
        wait_out(lat, rdy);
        check("add_latency", lat, 1);
        check("add_C", C, 0);
        check("add_Zero", Zero, 1);
        send(5'd4, 32'd0, 32'd1);
        #1 check("sub_C", C, 32'hFFFF_FFFF);
        check("sub_Zero", Zero, 0);

        send(5'd10, 32'h8000_0000, 32'd33);
        #1 check("sra_C", C, 32'hC000_0000);
        send(5'd12, 32'd1, 32'hFFFF_FFFF);
        #1 check("sltu_C", C, 1);
        send(5'd11, 32'd1, 32'hFFFF_FFFF);
        #1 check("slt_C", C, 0);

        send(5'd13, 32'd12345, 32'd6789);
        in_valid = 1'b1; ALUOp = 5'd3; A = $urandom; B = $urandom;
        wait_out(lat, rdy);
        in_valid = 1'b0;
        exp_v = 32'd12345 * 32'd6789;
        check("mul_latency", lat, W + 1);
        check("mul_in_ready_busy", rdy, 0);
        check("mul_C", C, exp_v);

        send(5'd13, 32'd5, 32'd6);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midmul_rst_C", C, 0);
        check("midmul_rst_Zero", Zero, 1);
        check("midmul_rst_out_valid", out_valid, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1 check("midmul_rst_idle", in_ready, 1);
        repeat (40) @(negedge clk);
        check("midmul_rst_no_result", out_valid, 0);

        out_ready = 1'b0;
        send(5'd3, 32'd100, 32'd23);
        in_valid = 1'b1; ALUOp = 5'd4;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_hold_C", C, 123);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            @(negedge clk);
            A = $urandom; B = $urandom;
        end
        a0 = acc_cnt; h0 = hs_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(0, 12);
            ALUOp = r[4:0]; A = pick(); B = pick();
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check("stream_accepts", acc_cnt - a0, 8);
        check("stream_results", hs_cnt - h0, 8);

        send(5'd13, $urandom, $urandom);
        repeat (8) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; ALUOp = 5'd3;
        #1 check("flush_blocks_accept", in_ready, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_mul_out_valid", out_valid, 0);
        check("flush_mul_in_ready", in_ready, 1);
        check("flush_mul_C_kept", C, model_c);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("flush_mul_no_result", seen, 0);

        out_ready = 1'b0;
        send(5'd7, 32'hA5A5_0000, 32'h0000_5A5A);
        flush = 1'b1; in_valid = 1'b1; ALUOp = 5'd3;
        #1 check("flush_idle_in_ready", in_ready, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("flush_drop_out_valid", out_valid, 0);
        check("flush_drop_C_kept", C, 32'hA5A5_5A5A);

        send(5'h1F, $urandom, $urandom);
        #1;
        check("illegal_flag", illegal, 1);
        check("illegal_C", C, 0);
        check("illegal_Zero", Zero, 1);
        send(5'd3, 32'd1, 32'd2);
        #1;
        check("legal_after_illegal", illegal, 0);
        check("legal_after_illegal_C", C, 3);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            r = $urandom_range(0, 19);
            if (r < 14)       ALUOp = r[4:0];
            else if (r == 14) ALUOp = 5'h1F;
            else if (r == 15) ALUOp = 5'd13;
            else begin
                r = $urandom_range(14, 31);
                ALUOp = r[4:0];
            end
            A = pick(); B = pick();
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        seen = 0;
        while (sb.size() > 0 && seen < 100) begin
            @(negedge clk);
            seen++;
        end
        check("drain_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
